uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and baud divisor.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

    function automatic logic [31:0] baud_cycle(
        input int unsigned clk_mhz,
        input int unsigned baud
    );
        return 32'(clk_mhz * 32'd1_000_000 / baud);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// RST_VAL sets the value both flops hold during reset.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, valid/ready output.
// Output register holds one byte; extra deliveries raise overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 27,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [31:0] CYCLE = baud_cycle(CLK_FREQ, BAUD);
    localparam logic [31:0] HALF  = CYCLE >> 1;

    logic        rxs;
    uart_state_t state, state_d;
    logic [31:0] cnt, cnt_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  shreg, shreg_d;
    logic        done, done_d;
    logic        ferr_d;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_cnt_d;
            shreg   <= shreg_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 32'd1;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (cnt == HALF - 32'd1) begin
                    cnt_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == CYCLE - 32'd1) begin
                    cnt_d          = '0;
                    shreg_d[bit_cnt] = rxs;
                    if (bit_cnt == 3'd7) state_d = ST_STOP;
                    else bit_cnt_d = bit_cnt + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt == CYCLE - 32'd1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // done lags the stop sample by one clock; shreg is untouched until
    // the next frame's first data bit, so it is still intact here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            overrun   <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 27 MHz / 115200 baud.
// Negedge monitor records handshakes, error pulses and stability.
module tb_uart_rx;

    localparam int CYCLE = 234;
    localparam int HALF  = 117;
    localparam int LAT   = 3 + HALF + 9 * CYCLE + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLK_FREQ(27), .BAUD(115200)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got[$];
    int vcyc, fe, ov, stab, rise_cyc, t_start;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;
    int n_chk = 0, n_fail = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (valid && ready) got.push_back(data);
            if (valid) vcyc++;
            if (valid && !pv && rise_cyc < 0) rise_cyc = cyc;
            if (pv && !pr && valid && data != pd) stab++;
            if (frame_err) fe++;
            if (overrun) ov++;
        end
        pv = valid;
        pr = ready;
        pd = data;
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv();
    endtask

    task automatic clr();
        got.delete();
        vcyc = 0;
        fe = 0;
        ov = 0;
        rise_cyc = -1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bt,
                              input logic stop);
        rx = 1'b0;
        t_start = cyc;
        idle(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bt);
        end
        rx = stop;
        idle(bt);
        rx = 1'b1;
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    initial begin
        clr();
        stab = 0;
        idle(3);
        #1;
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        drv();
        rst = 1'b1;
        idle(10);

        clr();
        ready = 1'b1;
        send_frame(8'h55, CYCLE, 1'b1);
        idle(10);
        check("t1_count", 32'(got.size()), 32'd1);
        check("t1_data", 32'(got_at(0)), 32'h55);
        check("t1_vcyc", 32'(vcyc), 32'd1);
        check("t1_latency", 32'(rise_cyc - t_start), 32'(LAT));
        check("t1_ferr", 32'(fe), 32'd0);
        check("t1_ovr", 32'(ov), 32'd0);

        clr();
        ready = 1'b0;
        send_frame(8'hA5, CYCLE, 1'b1);
        send_frame(8'h3C, CYCLE, 1'b1);
        idle(10);
        check("t2_valid_held", 32'(valid), 32'd1);
        check("t2_data_held", 32'(data), 32'hA5);
        check("t2_ovr", 32'(ov), 32'd1);
        check("t2_none_taken", 32'(got.size()), 32'd0);
        ready = 1'b1;
        drv();
        ready = 1'b0;
        idle(5);
        check("t2_count", 32'(got.size()), 32'd1);
        check("t2_data", 32'(got_at(0)), 32'hA5);
        check("t2_valid_drop", 32'(valid), 32'd0);
        check("t2_ferr", 32'(fe), 32'd0);

        clr();
        ready = 1'b1;
        rx = 1'b0;
        idle(50);
        rx = 1'b1;
        idle(2 * CYCLE);
        check("t3_glitch_none", 32'(vcyc), 32'd0);
        check("t3_glitch_ferr", 32'(fe), 32'd0);
        send_frame(8'h0F, CYCLE, 1'b1);
        idle(10);
        check("t3_count", 32'(got.size()), 32'd1);
        check("t3_data", 32'(got_at(0)), 32'h0F);

        clr();
        send_frame(8'hFF, CYCLE, 1'b0);
        rx = 1'b0;
        idle(3 * CYCLE);
        rx = 1'b1;
        idle(CYCLE);
        check("t4_ferr", 32'(fe), 32'd1);
        check("t4_no_valid", 32'(vcyc), 32'd0);
        send_frame(8'h81, CYCLE, 1'b1);
        idle(10);
        check("t4_count", 32'(got.size()), 32'd1);
        check("t4_data", 32'(got_at(0)), 32'h81);
        check("t4_ferr_once", 32'(fe), 32'd1);

        clr();
        rx = 1'b0;
        idle(CYCLE);
        for (int i = 0; i < 4; i++) begin
            rx = (i < 2);
            idle(CYCLE);
        end
        rst = 1'b0;
        #1;
        check("t5_rst_data", 32'(data), 32'h00);
        check("t5_rst_valid", 32'(valid), 32'd0);
        check("t5_rst_ferr", 32'(frame_err), 32'd0);
        check("t5_rst_ovr", 32'(overrun), 32'd0);
        idle(3);
        rx = 1'b1;
        rst = 1'b1;
        idle(20);
        send_frame(8'h12, CYCLE, 1'b1);
        idle(CYCLE);
        check("t5_count", 32'(got.size()), 32'd1);
        check("t5_data", 32'(got_at(0)), 32'h12);
        check("t5_ferr", 32'(fe), 32'd0);

        clr();
        send_frame(8'h3A, 229, 1'b1);
        send_frame(8'hC5, 239, 1'b1);
        idle(10);
        check("t6_count", 32'(got.size()), 32'd2);
        check("t6_slow_fast0", 32'(got_at(0)), 32'h3A);
        check("t6_slow_fast1", 32'(got_at(1)), 32'hC5);
        check("t6_ferr", 32'(fe), 32'd0);

        check("data_stable", 32'(stab), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
